// File: rtl/uart_rx_mon_pkg.sv
// Shared types for the UART receive-side frame monitor.
// Contents:
//   rx_state_t       receiver FSM states
//   rx_frame_t       one received frame with its classification flags
//   expected_parity  parity bit a correct transmitter would have sent
package uart_rx_mon_pkg;

    // Widest legal frame; narrower instances zero-extend into this.
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // 'break' is a keyword, hence brk.
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] data;
        logic                      parity_err;
        logic                      frame_err;
        logic                      brk;
    } rx_frame_t;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                             input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// Synchronous FIFO of received frames.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push, push_frame  write request and the frame to store
//   pop               remove the head entry
//   head              current head entry (meaningful only when !empty)
//   full, empty       occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_frame_fifo
    import uart_rx_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_frame_t push_frame,
    input  logic      pop,
    output rx_frame_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    rx_frame_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_frame;
        end
    end

endmodule

// File: rtl/uart_rx_frame_monitor.sv
// UART receive monitor: oversamples rx, rebuilds frames, classifies them
// (parity / framing / break) and queues them behind a valid/ready port.
// Ports:
//   pclk, areset       system clock, asynchronous active-high reset
//   sample_tick        one-cycle pulse at OVERSAMPLE x baud
//   rx                 serial line, idle high, asynchronous to pclk
//   out_valid/ready    head-of-queue handshake
//   out_data           received data bits, LSB first on the line
//   out_parity_err     parity mismatch
//   out_frame_err      a stop bit was sampled low
//   out_break          line low through data, parity and first stop bit
//   overrun_cnt        frames dropped on a full queue, saturating
//   busy               receiver is not idle
module uart_rx_frame_monitor
    import uart_rx_mon_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  sample_tick,
    input  logic                  rx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_parity_err,
    output logic                  out_frame_err,
    output logic                  out_break,
    output logic [15:0]           overrun_cnt,
    output logic                  busy
);

    localparam int   HALF       = OVERSAMPLE / 2;
    localparam int   CW         = $clog2(OVERSAMPLE);
    localparam int   BW         = $clog2(DATA_WIDTH);
    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam logic PAR_ODD    = (PARITY_ODD != 0);

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    rx_state_t             state;
    rx_state_t             state_next;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  stop_idx;
    logic                  stop_low;
    logic                  half_done;
    logic                  bit_done;
    logic                  last_stop;
    logic                  is_break;
    logic                  cnt_clr;
    logic                  shift_en;
    logic                  par_en;
    logic                  stop_en;
    logic                  frame_done;
    logic                  push_req;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    rx_frame_t             frame_now;
    rx_frame_t             push_frame;
    rx_frame_t             head;
    logic                  unused_head;

    // Preset to 1 so reset never looks like a falling edge on the line.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign half_done = sample_tick && (cnt == CW'(HALF - 1));
    assign bit_done  = sample_tick && (cnt == CW'(OVERSAMPLE - 1));
    assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;

    // Break is judged on the first stop sample: everything so far was low.
    assign is_break  = !stop_idx && (shreg == '0) && !(HAS_PARITY && par_bit) && !rx_sync;

    always_comb begin
        frame_now            = '0;
        frame_now.data       = MAX_DATA_WIDTH'(shreg);
        frame_now.parity_err = HAS_PARITY &&
                               (par_bit != expected_parity(MAX_DATA_WIDTH'(shreg), PAR_ODD));
        frame_now.frame_err  = stop_low || !rx_sync;
        frame_now.brk        = is_break;
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    cnt_clr    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (half_done) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_idx == BW'(DATA_WIDTH - 1)) begin
                        state_next = HAS_PARITY ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    stop_en = 1'b1;
                    if (is_break) begin
                        frame_done = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (last_stop) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                // Stay here during a break so its low level is not a new start.
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // From START onwards the counter runs modulo OVERSAMPLE, so each later
    // sample lands in the middle of its bit.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_idx   <= 1'b0;
            stop_low   <= 1'b0;
            push_req   <= 1'b0;
            push_frame <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (sample_tick) begin
                cnt <= (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shreg <= {rx_sync, shreg[DATA_WIDTH-1:1]};
            end

            if (par_en) begin
                par_bit <= rx_sync;
            end

            if (state != STOP) begin
                stop_idx <= 1'b0;
            end else if (stop_en) begin
                stop_idx <= ~stop_idx;
            end

            if (state == START) begin
                stop_low <= 1'b0;
            end else if (stop_en && !rx_sync) begin
                stop_low <= 1'b1;
            end

            push_req <= frame_done;
            if (frame_done) begin
                push_frame <= frame_now;
            end
        end
    end

    // A full queue still takes the frame if the head leaves in the same cycle.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            overrun_cnt <= '0;
        end else if (push_req && fifo_full && !pop && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end

    uart_rx_frame_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (pclk),
        .rst       (areset),
        .push      (push_req),
        .push_frame(push_frame),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs are forced to zero when nothing is queued.
    assign out_valid      = !fifo_empty;
    assign pop            = out_valid && out_ready;
    assign out_data       = out_valid ? head.data[DATA_WIDTH-1:0] : '0;
    assign out_parity_err = out_valid && head.parity_err;
    assign out_frame_err  = out_valid && head.frame_err;
    assign out_break      = out_valid && head.brk;
    assign busy           = (state != IDLE);
    assign unused_head    = ^head.data;

endmodule

// File: doc/uart_rx_frame_monitor.md
Name: uart_rx_frame_monitor

Overview:
Synthesizable, parametrised receive-side monitor for the UART slave agent. It oversamples the rx line and reconstructs frames with configurable data width, parity and stop bits. Each frame is classified (parity, framing, break) and queued in a small FIFO behind a valid/ready port, so the slave monitor proxy or a scoreboard can drain it without losing frames. It replaces the passive slave monitor BFM shell with real sampling behaviour and sits in hdl_top beside the slave driver BFM.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, sample ticks per bit, even, legal 8..32
PARITY_EN, 1, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd (ignored if PARITY_EN=0)
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, frame FIFO entries, power of two, 2..16

Ports:
pclk  in  1  system clock
areset  in  1  asynchronous reset, active-high
sample_tick  in  1  one-cycle pulse at OVERSAMPLE x baud rate
rx  in  1  serial line, idle high, asynchronous to pclk
out_valid  out  1  FIFO head holds a frame
out_ready  in  1  consumer accepts head this cycle
out_data  out  DATA_WIDTH  received data bits
out_parity_err  out  1  parity mismatch on this frame
out_frame_err  out  1  a stop bit sampled low
out_break  out  1  line held low through the whole frame
overrun_cnt  out  16  frames dropped because FIFO full, saturating
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, synchroniser flops preset to 1. Reset mid-frame discards the partial frame; no push.
- rx goes through a 2-flop synchroniser; all decisions use the synchronised value. Sample counter advances only on sample_tick.
- IDLE: on a synchronised 1->0 transition, clear counter, go START.
- START: at tick OVERSAMPLE/2 (mid-bit): low -> DATA with counter cleared; high -> false start, back to IDLE, no push.
- DATA: sample every OVERSAMPLE ticks, shift LSB first; after DATA_WIDTH bits go PARITY if PARITY_EN, else STOP.
- PARITY: one sample. parity_err = (XOR of data ^ parity bit) != PARITY_ODD.
- STOP: STOP_BITS samples; frame_err set if any stop sample is low. After the last stop sample, push the frame in the next pclk cycle, then go IDLE.
- Break: data, parity (if present) and first stop bit all 0 -> out_break=1 and frame_err=1, data=0. The FSM then goes to state WAIT_HIGH and stays there until rx is high, so no false start is detected inside the break.
- Second stop bit low without break: frame_err=1, normal return to IDLE.
- Latency: with an empty FIFO, out_valid rises 2 pclk after the pclk carrying the final stop-sample tick (1 push, 1 registered head).
- FIFO: pop when out_valid && out_ready. Outputs stable while out_valid && !out_ready.
- Push when full without a pop: frame dropped, overrun_cnt +1, saturating at 16'hFFFF. Push when full with a pop in the same cycle: accepted, no overrun.
- sample_tick absent: FSM holds state indefinitely; no timeout.
- busy=1 in every state except IDLE.

Decomposition:
- Package uart_rx_mon_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH), frame struct (data, parity_err, frame_err, break), function computing expected parity from data and PARITY_ODD.
- Sub-module: uart_rx_frame_fifo, a parametrised sync FIFO of frame structs with full/empty flags and simultaneous push/pop support.
- The synchroniser stays inline.

Test Plan:
1. Default params, send 0xA5 with even parity bit 0 and 1 stop -> one frame: data=0xA5, all error flags 0, overrun_cnt=0.
2. Send 0x3C with parity bit forced 1 -> data=0x3C, parity_err=1, frame_err=0.
3. Hold rx low for 12 bit times, then release -> one frame: data=0x00, out_break=1, frame_err=1. No further frame until a new start bit.
4. Glitch rx low for 4 ticks only -> no frame, busy returns to 0 within OVERSAMPLE/2 ticks.
5. FIFO_DEPTH=4, out_ready=0, send 6 frames -> 4 queued in order, overrun_cnt=2. Then out_ready=1 -> frames 1..4 drained in order.
6. DATA_WIDTH=7, PARITY_EN=0, STOP_BITS=2, send 0x55 with second stop bit low -> data=0x55, frame_err=1. Assert areset mid-frame in a repeat run -> no frame, all outputs 0.
